// File: rtl/cbc_sequencer.sv
// CBC-mode block sequencer: chains plaintext blocks through an external block-cipher core.
// Optional CBC_DECRYPT_EN adds a per-job decrypt mode (decrypt input, core_dec output).
module cbc_sequencer #(
  parameter int unsigned NBLK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NBLK_W-1:0] nblk,
  input  logic [0:127]      key,
  input  logic [0:127]      iv,
  input  logic [0:127]      pt,
  input  logic              pt_valid,
  output logic              pt_ready,
  output logic [0:127]      ct,
  output logic              ct_valid,
  input  logic              ct_ready,
  output logic              core_start,
  output logic [0:127]      core_in,
  output logic [0:127]      core_key,
  input  logic              core_done,
  input  logic [0:127]      core_out,
  output logic              busy,
  output logic              done
`ifdef CBC_DECRYPT_EN
  ,
  input  logic              decrypt,
  output logic              core_dec
`endif
);

  typedef enum logic [2:0] {StIdle, StAccept, StCore, StEmit, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [0:127]      r_key, r_chain, r_core_in, r_ct;
  logic [NBLK_W-1:0] r_remaining;
  logic              r_core_pend;
  logic              r_zero_done;
  logic              w_dec;

`ifdef CBC_DECRYPT_EN
  logic r_decrypt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_decrypt <= 1'b0;
    end else if (r_state == StIdle && start && nblk != '0) begin
      r_decrypt <= decrypt;
    end
  end

  assign w_dec    = r_decrypt;
  assign core_dec = r_decrypt;
`else
  assign w_dec = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (start && nblk != '0) w_state_next = StAccept;
      StAccept: if (pt_valid) w_state_next = StCore;
      StCore:   if (core_done) w_state_next = StEmit;
      StEmit: begin
        if (ct_ready) begin
          w_state_next = (r_remaining == NBLK_W'(1)) ? StDone : StAccept;
        end
      end
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    pt_ready   = (r_state == StAccept);
    ct_valid   = (r_state == StEmit);
    core_start = (r_state == StCore) && r_core_pend;
    busy       = (r_state != StIdle);
    done       = (r_state == StDone) || r_zero_done;
    ct         = r_ct;
    core_in    = r_core_in;
    core_key   = r_key;
  end

  // Datapath; core_done outside CORE (e.g. from a request aborted by reset) is dropped here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key       <= '0;
      r_chain     <= '0;
      r_core_in   <= '0;
      r_ct        <= '0;
      r_remaining <= '0;
      r_core_pend <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_core_pend <= 1'b0;
      r_zero_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            if (nblk == '0) begin
              r_zero_done <= 1'b1;
            end else begin
              r_key       <= key;
              r_chain     <= iv;
              r_remaining <= nblk;
            end
          end
        end
        StAccept: begin
          if (pt_valid) begin
            r_core_in   <= w_dec ? pt : (pt ^ r_chain);
            r_core_pend <= 1'b1;
          end
        end
        StCore: begin
          if (core_done) begin
            // Decrypt chains on the consumed ciphertext, which is still held in r_core_in.
            r_ct    <= w_dec ? (core_out ^ r_chain) : core_out;
            r_chain <= w_dec ? r_core_in : core_out;
          end
        end
        StEmit: begin
          if (ct_ready) r_remaining <= r_remaining - NBLK_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cbc_sequencer.sv
// Directed bench for cbc_sequencer with an XOR stub core (done 3 cycles after core_start).
// Define CBC_DECRYPT_EN to also run the decrypt job.
module tb_cbc_sequencer;

  localparam int unsigned NBLK_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NBLK_W-1:0] nblk;
  logic [0:127]      key, iv, pt, ct, core_in, core_key, core_out;
  logic              pt_valid, pt_ready, ct_valid, ct_ready;
  logic              core_start, core_done, busy, done;
`ifdef CBC_DECRYPT_EN
  logic              decrypt, core_dec;
`endif

  int checks   = 0;
  int failures = 0;
  int n_cs     = 0;
  int n_done   = 0;
  int n_busy   = 0;
  int n_both   = 0;

  always #5 clk = ~clk;

  cbc_sequencer #(.NBLK_W(NBLK_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .nblk       (nblk),
    .key        (key),
    .iv         (iv),
    .pt         (pt),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .ct         (ct),
    .ct_valid   (ct_valid),
    .ct_ready   (ct_ready),
    .core_start (core_start),
    .core_in    (core_in),
    .core_key   (core_key),
    .core_done  (core_done),
    .core_out   (core_out),
    .busy       (busy),
    .done       (done)
`ifdef CBC_DECRYPT_EN
    ,
    .decrypt    (decrypt),
    .core_dec   (core_dec)
`endif
  );

  // Stub core: never reset, so a request aborted by rst still completes.
  logic         d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic [0:127] stub_res = '0;
  always @(posedge clk) begin
    d1 <= core_start;
    d2 <= d1;
    d3 <= d2;
    if (core_start) stub_res <= core_in ^ core_key;
  end
  assign core_done = d3;
  assign core_out  = stub_res;

  always @(posedge clk) begin
    if (core_start) n_cs++;
    if (done) n_done++;
    if (busy) n_busy++;
    if (pt_ready && ct_valid) n_both++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [NBLK_W-1:0] n, input logic [127:0] v,
                           input logic [127:0] k);
    nblk  = n;
    iv    = v;
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  // One block: push pt, optionally stall ct_ready, check and accept ct.
  task automatic send_block(input string tag, input logic [127:0] p, input logic [127:0] exp_ct,
                            input logic [127:0] exp_key, input int stall);
    int n;
    logic [0:127] held;
    int cs0;
    n = 0;
    while (!pt_ready && n < 50) begin tick(); n++; end
    chk({tag, "_pt_ready"}, pt_ready, 1);
    pt       = p;
    pt_valid = 1'b1;
    tick();
    pt_valid = 1'b0;
    chk({tag, "_core_start"}, core_start, 1);
    chk({tag, "_core_key"}, core_key, exp_key);
    tick();
    chk({tag, "_core_start_1cyc"}, core_start, 0);
    n = 0;
    while (!ct_valid && n < 50) begin tick(); n++; end
    chk({tag, "_ct_valid"}, ct_valid, 1);
    chk({tag, "_ct"}, ct, exp_ct);
    held = ct;
    cs0  = n_cs;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall_valid"}, ct_valid, 1);
      chk({tag, "_stall_ct"}, ct, held);
      chk({tag, "_stall_pt_ready"}, pt_ready, 0);
    end
    if (stall > 0) chk({tag, "_stall_no_core_start"}, 128'(n_cs - cs0), 0);
    ct_ready = 1'b1;
    tick();
    ct_ready = 1'b0;
  endtask

  initial begin
    int cs0, dn0, bz0;
    rst      = 1'b1;
    start    = 1'b0;
    nblk     = '0;
    key      = '0;
    iv       = '0;
    pt       = '0;
    pt_valid = 1'b0;
    ct_ready = 1'b0;
`ifdef CBC_DECRYPT_EN
    decrypt  = 1'b0;
`endif
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pt_ready", pt_ready, 0);
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_ct", ct, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst_core_key", core_key, 0);
    rst = 1'b0;
    tick();

    // Single block: (0x10 ^ 0x01) ^ 0xF0 = 0xE1; a start during DONE is ignored.
    dn0 = n_done;
    start_job(1, 128'h01, 128'hF0);
    send_block("j1", 128'h10, 128'hE1, 128'hF0, 0);
    chk("j1_done", done, 1);
    start = 1'b1;
    nblk  = 1;
    tick();
    start = 1'b0;
    chk("j1_done_1cyc", done, 0);
    chk("j1_start_in_done_ignored", busy, 0);
    chk("j1_done_count", 128'(n_done - dn0), 1);

    // Three blocks, iv=key=0; second block stalls ct_ready for 10 cycles.
    cs0 = n_cs;
    dn0 = n_done;
    start_job(3, 128'h0, 128'h0);
    send_block("j2b0", 128'h01, 128'h01, 128'h0, 0);
    send_block("j2b1", 128'h02, 128'h03, 128'h0, 10);
    send_block("j2b2", 128'h03, 128'h00, 128'h0, 0);
    chk("j2_done", done, 1);
    tick();
    chk("j2_idle", busy, 0);
    chk("j2_core_starts", 128'(n_cs - cs0), 3);
    chk("j2_done_count", 128'(n_done - dn0), 1);

    // Reset while in CORE; the stale core_done must not produce a ct.
    start_job(1, 128'h0, 128'h55);
    pt       = 128'h0F;
    pt_valid = 1'b1;
    tick();
    pt_valid = 1'b0;
    chk("abort_in_core", core_start, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_busy", busy, 0);
      chk("abort_ct_valid", ct_valid, 0);
    end
    chk("abort_ct_cleared", ct, 0);
    start_job(1, 128'h03, 128'hA0);
    send_block("post_abort", 128'h30, 128'h93, 128'hA0, 0);
    tick();

    // Zero-length job: done pulse only.
    cs0 = n_cs;
    dn0 = n_done;
    bz0 = n_busy;
    nblk  = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_1cyc", done, 0);
    tick();
    chk("zero_done_count", 128'(n_done - dn0), 1);
    chk("zero_busy_count", 128'(n_busy - bz0), 0);
    chk("zero_core_starts", 128'(n_cs - cs0), 0);

`ifdef CBC_DECRYPT_EN
    decrypt = 1'b1;
    start_job(3, 128'h0, 128'h0);
    decrypt = 1'b0;
    chk("dec_core_dec", core_dec, 1);
    send_block("dec0", 128'h01, 128'h01, 128'h0, 0);
    send_block("dec1", 128'h03, 128'h02, 128'h0, 0);
    send_block("dec2", 128'h00, 128'h03, 128'h0, 0);
    chk("dec_done", done, 1);
    tick();
`endif

    chk("never_pt_ready_and_ct_valid", 128'(n_both), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cbc_sequencer.md
CBC_SEQUENCER -- requirements
Module: cbc_sequencer

Interface
REQ-001 SHALL have parameter: NBLK_W, default 4, width of the per-job block count.
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  job request; sampled only in IDLE.
REQ-005 SHALL have port: nblk  input  NBLK_W  number of 128-bit blocks in the job.
REQ-006 SHALL have port: key  input  [0:127]  cipher key; latched on accepted start.
REQ-007 SHALL have port: iv  input  [0:127]  initialisation vector; latched on accepted start.
REQ-008 SHALL have port: pt, pt_valid, pt_ready  in/in/out  [0:127]/1/1  plaintext block stream.
REQ-009 SHALL have port: ct, ct_valid, ct_ready  out/out/in  [0:127]/1/1  ciphertext block stream.
REQ-010 SHALL have port: core_start, core_in, core_key  out/out/out  1/[0:127]/[0:127]  block-cipher core request.
REQ-011 SHALL have port: core_done, core_out  in/in  1/[0:127]  block-cipher core result; core latency arbitrary (>=1 cycle).
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle pulse at job end.

Function
REQ-014 SHALL implement states IDLE, ACCEPT, CORE, EMIT, DONE, one-hot or encoded.
REQ-015 SHALL, in IDLE with start=1 and nblk!=0, latch key, load chain register with iv, load remaining counter with nblk, and enter ACCEPT next cycle.
REQ-016 SHALL, in IDLE with start=1 and nblk=0, pulse done for one cycle on the next cycle, stay IDLE, and issue no core_start.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 SHALL assert pt_ready only in ACCEPT; on pt_valid&pt_ready register core_in = pt XOR chain and enter CORE.
REQ-019 SHALL assert core_start for exactly one cycle, the first cycle in CORE (1 cycle after the pt handshake).
REQ-020 SHALL hold core_in and core_key stable from core_start until core_done; core_key SHALL equal the latched key for the whole job.
REQ-021 SHALL, in CORE on core_done=1, register ct = core_out and chain = core_out, and enter EMIT; core_done in any other state SHALL be ignored.
REQ-022 SHALL assert ct_valid only in EMIT (1 cycle after core_done); ct SHALL stay stable while ct_valid=1 and ct_ready=0.
REQ-023 SHALL, on ct_valid&ct_ready, decrement remaining; if remaining was 1 enter DONE, else enter ACCEPT.
REQ-024 SHALL, in DONE, assert done for one cycle and return to IDLE; a start in that cycle is ignored.
REQ-025 SHALL never assert pt_ready and ct_valid in the same cycle (at most one block in flight).

Reset
REQ-026 SHALL, with rst=1 at a clock edge, enter IDLE and clear ct, core_in, core_key, chain, remaining and all control outputs (pt_ready, ct_valid, core_start, busy, done) to 0.
REQ-027 SHALL, on reset mid-job, abandon the job; a core_done from the aborted request arriving after reset SHALL have no effect.
REQ-028 SHALL give rst priority over every other input in the same cycle.

Configuration
REQ-029 SHALL, with macro CBC_DECRYPT_EN defined, add input decrypt (1 bit, latched on accepted start) and output core_dec (= latched decrypt); in decrypt jobs core_in = pt, ct = core_out XOR chain, and chain = the consumed pt block.
REQ-030 SHALL, without CBC_DECRYPT_EN, omit decrypt and core_dec and perform encryption only as REQ-018..REQ-023.

Verification (stub core: core_out = core_in XOR core_key, core_done 3 cycles after core_start)
REQ-031 SHALL cover: nblk=1, iv=0x...01, key=0x...F0, pt=0x...10 -> one ct=0x...E1, then done pulse once, busy low.
REQ-032 SHALL cover: nblk=3, pt blocks 0x...01/0x...02/0x...03, iv=0, key=0 -> ct 0x...01, 0x...03, 0x...00; exactly 3 core_start pulses and one done.
REQ-033 SHALL cover: ct_ready held 0 for 10 cycles in EMIT -> ct_valid stays 1, ct unchanged, pt_ready stays 0, no core_start.
REQ-034 SHALL cover: rst pulsed while in CORE, stub core_done arrives 2 cycles later -> busy=0, ct_valid=0, no ct emitted; following nblk=1 job yields the correct ct.
REQ-035 SHALL cover: start with nblk=0 -> done high exactly one cycle, busy never high, core_start never high.
REQ-036 SHALL cover (CBC_DECRYPT_EN): decrypt job fed the REQ-032 ciphertexts with same iv/key -> outputs 0x...01, 0x...02, 0x...03.
